// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with per-packet grant locking.
// Registered one-hot grant plus binary index of the winner.
module one_hot_2_index #(
  parameter int NUM_IN     = 4,
  parameter int INDEX_SIZE = 2
) (
  input  logic [NUM_IN-1:0]     one_hot,
  output logic [INDEX_SIZE-1:0] index
);

  always_comb begin
    index = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (one_hot[i]) begin
        index = index | INDEX_SIZE'(i);
      end
    end
  end

endmodule

module rr_grant_arbiter #(
  parameter int NUM_REQS   = 4,
  parameter int INDEX_SIZE = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQS-1:0]   request,
  output logic [NUM_REQS-1:0]   grant,
  output logic                  grant_valid,
  output logic [INDEX_SIZE-1:0] grant_index
);

  logic [NUM_REQS-1:0]   grant_q;
  logic [NUM_REQS-1:0]   grant_nxt;
  logic [INDEX_SIZE-1:0] ptr_q;
  logic [INDEX_SIZE-1:0] ptr_nxt;
  logic [INDEX_SIZE-1:0] win;
  logic [INDEX_SIZE-1:0] idx_b;
  logic                  found;
  logic                  held;

  // Circular scan starting at ptr; each line visited exactly once.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_b = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQS) begin
        idx = idx - NUM_REQS;
      end
      idx_b = INDEX_SIZE'(idx);
      if (!found && request[idx_b]) begin
        found = 1'b1;
        win   = idx_b;
      end
    end
  end

  assign held = |(grant_q & request);

  always_comb begin
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    if (!held) begin
      grant_nxt = '0;
      if (found) begin
        grant_nxt[win] = 1'b1;
        ptr_nxt = (int'(win) == NUM_REQS - 1) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ptr_q   <= '0;
    end else begin
      grant_q <= grant_nxt;
      ptr_q   <= ptr_nxt;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;

  one_hot_2_index #(
    .NUM_IN     (NUM_REQS),
    .INDEX_SIZE (INDEX_SIZE)
  ) u_idx (
    .one_hot (grant_q),
    .index   (grant_index)
  );

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: 4-way and 5-way instances,
// vector tables plus a queue scoreboard of expected grants.
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req4 = '0;
  logic [3:0] g4;
  logic       v4;
  logic [1:0] i4;
  logic [4:0] req5 = '0;
  logic [4:0] g5;
  logic       v5;
  logic [2:0] i5;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0] req;
    logic [4:0] g;
    logic [2:0] idx;
  } vec_t;

  typedef struct {
    bit         sel5;
    logic [4:0] g;
    logic [2:0] idx;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t rot[9];
  vec_t alt5[4];

  always #5 clk = ~clk;

  rr_grant_arbiter #(.NUM_REQS(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (req4),
    .grant       (g4),
    .grant_valid (v4),
    .grant_index (i4)
  );

  rr_grant_arbiter #(.NUM_REQS(5)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .request     (req5),
    .grant       (g5),
    .grant_valid (v5),
    .grant_index (i5)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one request vector, queue its expectation, compare after the edge.
  task automatic step(input bit sel5, input logic [4:0] req,
                      input logic [4:0] eg, input logic [2:0] ei,
                      input string name);
    exp_t e;
    if (sel5) req5 = req;
    else req4 = req[3:0];
    e.sel5 = sel5;
    e.g    = eg;
    e.idx  = ei;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.sel5) begin
      check({e.name, " grant"}, 32'(g5), 32'(e.g));
      check({e.name, " idx"}, 32'(i5), 32'(e.idx));
      check({e.name, " valid"}, 32'(v5), 32'(e.g != 0));
      check({e.name, " onehot"}, 32'($countones(g5) <= 1), 32'd1);
    end else begin
      check({e.name, " grant"}, 32'(g4), 32'(e.g));
      check({e.name, " idx"}, 32'(i4), 32'(e.idx));
      check({e.name, " valid"}, 32'(v4), 32'(e.g != 0));
    end
  endtask

  task automatic check_zero4(input string name);
    check({name, " grant"}, 32'(g4), 32'd0);
    check({name, " valid"}, 32'(v4), 32'd0);
    check({name, " idx"}, 32'(i4), 32'd0);
  endtask

  initial begin
    rot[0] = '{5'b01111, 5'b00001, 3'd0};
    rot[1] = '{5'b01111, 5'b00001, 3'd0};
    rot[2] = '{5'b01110, 5'b00010, 3'd1};
    rot[3] = '{5'b01111, 5'b00010, 3'd1};
    rot[4] = '{5'b01101, 5'b00100, 3'd2};
    rot[5] = '{5'b01111, 5'b00100, 3'd2};
    rot[6] = '{5'b01011, 5'b01000, 3'd3};
    rot[7] = '{5'b01111, 5'b01000, 3'd3};
    rot[8] = '{5'b00111, 5'b00001, 3'd0};
    alt5[0] = '{5'b10001, 5'b00001, 3'd0};
    alt5[1] = '{5'b10000, 5'b10000, 3'd4};
    alt5[2] = '{5'b00001, 5'b00001, 3'd0};
    alt5[3] = '{5'b10000, 5'b10000, 3'd4};

    // Reset holds everything at zero despite requests.
    req4 = 4'b1111;
    #1;
    check_zero4("rst_imm");
    repeat (2) @(posedge clk);
    #1;
    check_zero4("rst_held");
    check("rst5 grant", 32'(g5), 32'd0);

    // Single request and lock.
    req4 = 4'b0000;
    rst_n = 1'b1;
    step(0, 5'b01000, 5'b01000, 3'd3, "single");
    for (int i = 0; i < 5; i++) begin
      step(0, 5'b01000, 5'b01000, 3'd3, "lock_hold");
    end
    step(0, 5'b01001, 5'b01000, 3'd3, "lock_ignore");
    step(0, 5'b00000, 5'b00000, 3'd0, "lock_release");

    // Rotation from ptr=0 including wrap.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step(0, rot[i].req, rot[i].g, rot[i].idx, $sformatf("rot%0d", i));
    end

    // Back-to-back handoff, then drain to idle.
    step(0, 5'b00110, 5'b00010, 3'd1, "hand_a");
    step(0, 5'b00110, 5'b00010, 3'd1, "hand_b");
    step(0, 5'b00100, 5'b00100, 3'd2, "hand_c");
    step(0, 5'b00000, 5'b00000, 3'd0, "hand_idle");

    // Async reset mid-lock: grant=0100, ptr=3.
    step(0, 5'b00100, 5'b00100, 3'd2, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero4("mid_rst");
    rst_n = 1'b1;
    step(0, 5'b01001, 5'b00001, 3'd0, "post_rst");
    step(0, 5'b00000, 5'b00000, 3'd0, "post_idle");

    // Five requesters, lines 0 and 4 trading the grant.
    for (int i = 0; i < 4; i++) begin
      step(1, alt5[i].req, alt5[i].g, alt5[i].idx, $sformatf("n5_%0d", i));
    end
    check("n4 quiet", 32'(g4), 32'd0);
    check("sb empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
